// File: rtl/stream_gen_fifo.sv
// Circular FIFO fed by a push port and drained through a registered valid/ready stream.
// Optional fixed-length packet framing drives tlast alongside each loaded beat.
module stream_gen_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Din,
    input  logic              push,
    input  logic              op_en,
    input  logic [CNT_W-1:0]  pkt_len,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              tlast,
    output logic [CNT_W-1:0]  buff_count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_bcnt;
    logic [CNT_W-1:0]  r_len;

    logic              w_full;
    logic              w_push_ok;
    logic              w_load;
    logic [CNT_W-1:0]  w_len;
    logic              w_last;
    logic [CNT_W-1:0]  w_bcnt_next;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push_ok = push && !w_full;
    assign w_load    = op_en && (r_count != '0) && (!r_tvalid || tready);

    // Packet length is latched on the first beat; later beats use the held copy.
    always_comb begin
        w_len       = (r_bcnt == '0) ? pkt_len : r_len;
        w_last      = 1'b0;
        w_bcnt_next = r_bcnt;
        if (w_len != '0) begin
            w_last = (r_bcnt == (w_len - CNT_W'(1)));
        end else begin
            w_last = (r_count == CNT_W'(1)) && !w_push_ok;
        end
        if (w_last) begin
            w_bcnt_next = '0;
        end else if (r_bcnt != '1) begin
            w_bcnt_next = r_bcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wptr] <= Din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_overflow <= 1'b0;
            r_bcnt     <= '0;
            r_len      <= '0;
        end else begin
            r_overflow <= push && w_full;
            if (w_push_ok) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_load) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_push_ok, w_load})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_tdata  <= r_mem[r_rptr];
                r_tvalid <= 1'b1;
                r_tlast  <= w_last;
                r_bcnt   <= w_bcnt_next;
                if (r_bcnt == '0) begin
                    r_len <= pkt_len;
                end
            end else if (r_tvalid && tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

    assign tdata      = r_tdata;
    assign tvalid     = r_tvalid;
    assign tlast      = r_tlast;
    assign buff_count = r_count;
    assign empty      = (r_count == '0);
    assign full       = w_full;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_stream_gen_fifo.sv
// Randomised bench for stream_gen_fifo: queue-based reference model checked every cycle,
// an in-order transfer scoreboard, and literal expectations for the directed scenarios.
module tb_stream_gen_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              push;
    logic              op_en;
    logic [CNT_W-1:0]  pkt_len;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [CNT_W-1:0]  buff_count;
    logic              empty;
    logic              full;
    logic              overflow;

    always #5 clk = ~clk;

    stream_gen_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Din(din), .push(push), .op_en(op_en), .pkt_len(pkt_len),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .buff_count(buff_count), .empty(empty), .full(full), .overflow(overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO contents as a queue, output beat as plain values.
    int m_q[$];
    int m_tvalid = 0, m_tdata = 0, m_tlast = 0, m_ovf = 0;
    int m_beats = 0, m_plen = 0;
    int exp_acc[$];
    int xd[$];
    int xl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        int  sz;
        bit  is_full, pok, ld, last;
        // Scoreboard: a beat handed over at this edge must be the oldest accepted word.
        if (!rst && tvalid === 1'b1 && tready) begin
            xd.push_back(int'(tdata));
            xl.push_back(int'(tlast));
            if (exp_acc.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL xfer_extra: got beat %0d expected no beat (t=%0t)", tdata, $time);
            end else begin
                chk("xfer_order", 32'(tdata), 32'(exp_acc.pop_front()));
            end
        end
        if (rst) begin
            m_q.delete();
            exp_acc.delete();
            m_tvalid = 0; m_tdata = 0; m_tlast = 0; m_ovf = 0; m_beats = 0; m_plen = 0;
        end else begin
            sz      = m_q.size();
            is_full = (sz == DEPTH);
            pok     = push && !is_full;
            ld      = op_en && (sz > 0) && (m_tvalid == 0 || tready);
            if (ld) begin
                if (m_beats == 0) m_plen = int'(pkt_len);
                if (m_plen != 0) last = (m_beats + 1 == m_plen);
                else             last = (sz == 1) && !pok;
                m_tdata  = m_q.pop_front();
                m_tvalid = 1;
                m_tlast  = int'(last);
                m_beats  = last ? 0 : m_beats + 1;
            end else if (m_tvalid != 0 && tready) begin
                m_tvalid = 0;
                m_tlast  = 0;
            end
            if (pok) begin
                m_q.push_back(int'(din));
                exp_acc.push_back(int'(din));
            end
            m_ovf = int'(push && is_full);
        end
        @(posedge clk);
        #1;
        chk("tvalid", 32'(tvalid), 32'(m_tvalid));
        chk("tdata", 32'(tdata), 32'(m_tdata));
        chk("tlast", 32'(tlast), 32'(m_tlast));
        chk("buff_count", 32'(buff_count), 32'(m_q.size()));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        rst = 1'b1; push = 1'b1; din = 8'h00; op_en = 1'b0; tready = 1'b0; pkt_len = '0;

        // Reset with push held high
        repeat (2) cycle();
        chk("rst_count", 32'(buff_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_tvalid", 32'(tvalid), 32'd0);

        // Fill, overflow, drain in packet-on-empty mode
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; din = 8'(i);
            cycle();
        end
        chk("fill_count", 32'(buff_count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        din = 8'hAA;
        cycle();
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(buff_count), 32'd16);
        push = 1'b0;
        cycle();
        chk("ovf_clear", 32'(overflow), 32'd0);
        xd.delete(); xl.delete();
        op_en = 1'b1; tready = 1'b1; pkt_len = '0;
        repeat (20) cycle();
        chk("drain_n", 32'(xd.size()), 32'd16);
        for (int i = 0; i < 16 && i < xd.size(); i++) begin
            chk("drain_data", 32'(xd[i]), 32'(i));
            chk("drain_last", 32'(xl[i]), 32'(i == 15));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Backpressure
        op_en = 1'b0; tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; din = 8'($urandom_range(0, 255));
            cycle();
        end
        push = 1'b0; op_en = 1'b1; xd.delete(); xl.delete();
        repeat (60) begin
            tready = 1'($urandom_range(0, 1));
            cycle();
        end
        tready = 1'b1;
        repeat (3) cycle();
        chk("bp_n", 32'(xd.size()), 32'd8);

        // Fixed-length framing
        pkt_len = 5'd4; xd.delete(); xl.delete();
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; din = 8'(8'h40 + i);
            cycle();
        end
        push = 1'b0;
        repeat (4) cycle();
        for (int i = 0; i < 2; i++) begin
            push = 1'b1; din = 8'(8'h60 + i);
            cycle();
        end
        push = 1'b0;
        repeat (4) cycle();
        chk("frame_n", 32'(xd.size()), 32'd12);
        chk("frame_b4", 32'(xl[3]), 32'd1);
        chk("frame_b8", 32'(xl[7]), 32'd1);
        chk("frame_b9", 32'(xl[8]), 32'd0);
        chk("frame_b10", 32'(xl[9]), 32'd0);
        chk("frame_b12", 32'(xl[11]), 32'd1);
        chk("frame_d12", 32'(xd[11]), 32'h61);

        // Continuous streaming across pointer wrap
        pkt_len = '0; xd.delete(); xl.delete();
        for (int i = 0; i < 40; i++) begin
            push = 1'b1; din = 8'($urandom_range(0, 255));
            cycle();
            chk("wrap_le1", 32'(buff_count <= 1), 32'd1);
        end
        push = 1'b0;
        repeat (3) cycle();
        chk("wrap_n", 32'(xd.size()), 32'd40);

        // Reset while a beat is stalled
        op_en = 1'b0; tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; din = 8'(8'h80 + i);
            cycle();
        end
        push = 1'b0; op_en = 1'b1;
        repeat (2) cycle();
        chk("stall_count", 32'(buff_count), 32'd5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst6_tvalid", 32'(tvalid), 32'd0);
        chk("rst6_empty", 32'(empty), 32'd1);
        xd.delete(); xl.delete();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; din = 8'(8'hC0 + i);
            cycle();
        end
        push = 1'b0; tready = 1'b1;
        repeat (5) cycle();
        chk("rst6_n", 32'(xd.size()), 32'd3);
        chk("rst6_first", 32'(xd[0]), 32'hC0);

        // Random mix
        for (int i = 0; i < 500; i++) begin
            push   = ($urandom_range(0, 9) < 7);
            din    = 8'($urandom_range(0, 255));
            op_en  = ($urandom_range(0, 9) < 8);
            tready = ($urandom_range(0, 9) < 6);
            rst    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) pkt_len = 5'($urandom_range(0, 5));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
